// File: rtl/render_sequencer_if.sv
// render_sequencer_if
//   Groups the shape-drawer handshake and the framebuffer write port of the
//   render sequencer into one bundle.
//
//   Drawer side : shape_idx_out, draw_start_out (sequencer -> drawer)
//                 draw_hcount_in, draw_vcount_in, draw_color_in,
//                 draw_valid_in, draw_done_in (drawer -> sequencer)
//   Framebuffer : fb_addr_out, fb_data_out, fb_we_out, fb_sel_out
//                 (sequencer -> pixel RAM)
//
//   Modports: master = the sequencer, slave = drawer + framebuffer side.
//
//   Handshake semantics: draw_start_out is a one-cycle command pulse with
//   shape_idx_out valid in the same cycle. The drawer has no back-pressure.
//   Every cycle with draw_valid_in high offers one pixel, and the sequencer
//   always accepts it. The shape ends on the cycle draw_done_in is high,
//   and a pixel offered in that same cycle still counts. fb_we_out qualifies
//   fb_addr_out/fb_data_out for exactly one cycle per write. The RAM must
//   accept a write every cycle.
interface render_sequencer_if #(
  parameter int PIXEL_WIDTH  = 1280,
  parameter int PIXEL_HEIGHT = 720,
  parameter int COLOR_BITS   = 4,
  parameter int MAX_SHAPES   = 16
);
  localparam int AW = $clog2(PIXEL_WIDTH * PIXEL_HEIGHT);
  localparam int HW = $clog2(PIXEL_WIDTH);
  localparam int VW = $clog2(PIXEL_HEIGHT);
  localparam int SW = $clog2(MAX_SHAPES + 1);

  logic [SW-1:0]         shape_idx_out;
  logic                  draw_start_out;
  logic [HW:0]           draw_hcount_in;
  logic [VW:0]           draw_vcount_in;
  logic [COLOR_BITS-1:0] draw_color_in;
  logic                  draw_valid_in;
  logic                  draw_done_in;

  logic [AW-1:0]         fb_addr_out;
  logic [COLOR_BITS-1:0] fb_data_out;
  logic                  fb_we_out;
  logic                  fb_sel_out;

  modport master (
    output shape_idx_out, draw_start_out,
    input  draw_hcount_in, draw_vcount_in, draw_color_in,
    input  draw_valid_in, draw_done_in,
    output fb_addr_out, fb_data_out, fb_we_out, fb_sel_out
  );

  modport slave (
    input  shape_idx_out, draw_start_out,
    output draw_hcount_in, draw_vcount_in, draw_color_in,
    output draw_valid_in, draw_done_in,
    input  fb_addr_out, fb_data_out, fb_we_out, fb_sel_out
  );
endinterface

// File: rtl/render_sequencer.sv
// render_sequencer
//   Frame-level render controller for a double-buffered framebuffer. On
//   start it clears the back buffer to the background colour, one address per
//   cycle. It then runs up to MAX_SHAPES shapes through an external drawer
//   and forwards the in-range, non-transparent pixels to the framebuffer. It
//   swaps buffers on the next vsync.
//
//   Ports:
//     clk_in, rst_in          clock, asynchronous active-high reset
//     start_in                frame request, sampled only in IDLE
//     vsync_in                frame-boundary pulse, honoured only in WAIT_SWAP
//     background_color_in     clear colour, latched on start
//     num_shapes_in           shape count, latched on start and clamped
//                             to MAX_SHAPES
//     bus                     drawer handshake + framebuffer write port
//     display_buf_out         buffer currently scanned out
//     busy_out                high in every state except IDLE
//     frame_done_out          one-cycle pulse on the buffer swap
//     state_dbg_out           current FSM state encoding (debug)
//
//   All outputs come straight from flops. The combinational block computes
//   the next value of every output, and the single register block stores it.
module render_sequencer #(
  parameter int PIXEL_WIDTH  = 1280,
  parameter int PIXEL_HEIGHT = 720,
  parameter int COLOR_BITS   = 4,
  parameter int MAX_SHAPES   = 16,
  parameter logic [COLOR_BITS-1:0] TRANSPARENT = COLOR_BITS'(4'hF),
  localparam int AW = $clog2(PIXEL_WIDTH * PIXEL_HEIGHT),
  localparam int HW = $clog2(PIXEL_WIDTH),
  localparam int VW = $clog2(PIXEL_HEIGHT),
  localparam int SW = $clog2(MAX_SHAPES + 1)
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic                  vsync_in,
  input  logic [COLOR_BITS-1:0] background_color_in,
  input  logic [SW-1:0]         num_shapes_in,
  render_sequencer_if.master    bus,
  output logic                  display_buf_out,
  output logic                  busy_out,
  output logic                  frame_done_out,
  output logic [2:0]            state_dbg_out
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CLEAR      = 3'd1,
    ST_DRAW_START = 3'd2,
    ST_DRAW_WAIT  = 3'd3,
    ST_WAIT_SWAP  = 3'd4
  } state_t;

  localparam int              NPIX       = PIXEL_WIDTH * PIXEL_HEIGHT;
  localparam logic [AW-1:0]   LAST_ADDR  = AW'(NPIX - 1);
  localparam logic [AW-1:0]   ROW_STRIDE = AW'(PIXEL_WIDTH);
  localparam logic [HW:0]     H_LIMIT    = (HW + 1)'(PIXEL_WIDTH);
  localparam logic [VW:0]     V_LIMIT    = (VW + 1)'(PIXEL_HEIGHT);
  localparam logic [SW-1:0]   SHAPE_MAX  = SW'(MAX_SHAPES);

  // Registered state and outputs
  state_t                state_q,  state_d;
  logic [AW-1:0]         clr_q,    clr_d;     // address shown on fb_addr_out during CLEAR
  logic [SW-1:0]         idx_q,    idx_d;
  logic [SW-1:0]         cnt_q,    cnt_d;
  logic [COLOR_BITS-1:0] bg_q,     bg_d;
  logic [AW-1:0]         addr_q,   addr_d;
  logic [COLOR_BITS-1:0] data_q,   data_d;
  logic                  we_q,     we_d;
  logic                  dstart_q, dstart_d;
  logic                  disp_q,   disp_d;
  logic                  sel_q,    sel_d;
  logic                  busy_q,   busy_d;
  logic                  fdone_q,  fdone_d;

  // Pixel qualification and address. The range check runs first, so the
  // truncated coordinates used for the address are always in range, and the
  // AW-bit product y*PIXEL_WIDTH + x cannot wrap.
  logic                  pixel_ok;
  logic [AW-1:0]         pixel_addr;
  logic [SW-1:0]         num_clamped;

  always_comb begin
    pixel_ok = bus.draw_valid_in &&
               (bus.draw_hcount_in < H_LIMIT) &&
               (bus.draw_vcount_in < V_LIMIT) &&
               (bus.draw_color_in != TRANSPARENT);
    pixel_addr = AW'(bus.draw_vcount_in[VW-1:0]) * ROW_STRIDE +
                 AW'(bus.draw_hcount_in[HW-1:0]);
    num_clamped = (num_shapes_in > SHAPE_MAX) ? SHAPE_MAX : num_shapes_in;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d  = state_q;
    clr_d    = clr_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    bg_d     = bg_q;
    addr_d   = addr_q;
    data_d   = data_q;
    we_d     = 1'b0;
    dstart_d = 1'b0;
    disp_d   = disp_q;
    fdone_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          // The first clear write (address 0) is issued on this edge, so it
          // appears in the cycle right after start is sampled.
          bg_d    = background_color_in;
          cnt_d   = num_clamped;
          idx_d   = '0;
          clr_d   = '0;
          we_d    = 1'b1;
          addr_d  = '0;
          data_d  = background_color_in;
          state_d = ST_CLEAR;
        end
      end

      ST_CLEAR: begin
        if (clr_q == LAST_ADDR) begin
          if (cnt_q != '0) begin
            dstart_d = 1'b1;
            state_d  = ST_DRAW_START;
          end else begin
            state_d  = ST_WAIT_SWAP;
          end
        end else begin
          clr_d  = clr_q + AW'(1);
          we_d   = 1'b1;
          addr_d = clr_q + AW'(1);
          data_d = bg_q;
        end
      end

      // draw_start_out is high for exactly this one cycle
      ST_DRAW_START: begin
        state_d = ST_DRAW_WAIT;
      end

      ST_DRAW_WAIT: begin
        if (pixel_ok) begin
          we_d   = 1'b1;
          addr_d = pixel_addr;
          data_d = bus.draw_color_in;
        end
        if (bus.draw_done_in) begin
          if (idx_q == cnt_q - SW'(1)) begin
            state_d = ST_WAIT_SWAP;
          end else begin
            idx_d    = idx_q + SW'(1);
            dstart_d = 1'b1;
            state_d  = ST_DRAW_START;
          end
        end
      end

      ST_WAIT_SWAP: begin
        if (vsync_in) begin
          disp_d  = ~disp_q;
          fdone_d = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    sel_d  = ~disp_d;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q  <= ST_IDLE;
      clr_q    <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      bg_q     <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      dstart_q <= 1'b0;
      disp_q   <= 1'b0;
      sel_q    <= 1'b1;
      busy_q   <= 1'b0;
      fdone_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      clr_q    <= clr_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      bg_q     <= bg_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      dstart_q <= dstart_d;
      disp_q   <= disp_d;
      sel_q    <= sel_d;
      busy_q   <= busy_d;
      fdone_q  <= fdone_d;
    end
  end

  assign bus.shape_idx_out  = idx_q;
  assign bus.draw_start_out = dstart_q;
  assign bus.fb_addr_out    = addr_q;
  assign bus.fb_data_out    = data_q;
  assign bus.fb_we_out      = we_q;
  assign bus.fb_sel_out     = sel_q;
  assign display_buf_out    = disp_q;
  assign busy_out           = busy_q;
  assign frame_done_out     = fdone_q;
  assign state_dbg_out      = state_q;

endmodule

// File: tb/tb_render_sequencer.sv
// Directed bench for render_sequencer on an 8x4 framebuffer.
module tb_render_sequencer;
  localparam int PW = 8;
  localparam int PH = 4;
  localparam int CB = 4;
  localparam int MS = 16;
  localparam int AW = $clog2(PW * PH);
  localparam int HW = $clog2(PW);
  localparam int VW = $clog2(PH);
  localparam int SW = $clog2(MS + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_DSTRT = 3'd2;
  localparam logic [2:0] S_DWAIT = 3'd3;
  localparam logic [2:0] S_SWAP  = 3'd4;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic          start_in;
  logic          vsync_in;
  logic [CB-1:0] background_color_in;
  logic [SW-1:0] num_shapes_in;
  logic          display_buf_out;
  logic          busy_out;
  logic          frame_done_out;
  logic [2:0]    state_dbg_out;

  int   errors = 0;
  int   checks = 0;
  logic exp_disp = 1'b0;

  render_sequencer_if #(
    .PIXEL_WIDTH(PW), .PIXEL_HEIGHT(PH), .COLOR_BITS(CB), .MAX_SHAPES(MS)
  ) bus ();

  render_sequencer #(
    .PIXEL_WIDTH(PW), .PIXEL_HEIGHT(PH), .COLOR_BITS(CB), .MAX_SHAPES(MS),
    .TRANSPARENT(4'hF)
  ) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .start_in            (start_in),
    .vsync_in            (vsync_in),
    .background_color_in (background_color_in),
    .num_shapes_in       (num_shapes_in),
    .bus                 (bus),
    .display_buf_out     (display_buf_out),
    .busy_out            (busy_out),
    .frame_done_out      (frame_done_out),
    .state_dbg_out       (state_dbg_out)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs/outputs are then handled 1 time unit after the edge.
  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_pixel(input int x, input int y, input logic [CB-1:0] c);
    bus.draw_hcount_in = (HW + 1)'(x);
    bus.draw_vcount_in = (VW + 1)'(y);
    bus.draw_color_in  = c;
    bus.draw_valid_in  = 1'b1;
  endtask

  // Issues start from IDLE and checks all PW*PH clear writes. If hold is set,
  // start stays high and the background input is disturbed mid-clear; neither
  // may affect the clear. Returns in the cycle holding the last clear write.
  task automatic run_clear(input logic [CB-1:0] bg, input logic [SW-1:0] n, input bit hold);
    background_color_in = bg;
    num_shapes_in       = n;
    start_in            = 1'b1;
    tick;
    if (!hold) start_in = 1'b0;
    for (int k = 0; k < PW * PH; k++) begin
      checks++;
      if ({busy_out, bus.fb_we_out, bus.fb_addr_out, bus.fb_data_out, bus.draw_start_out, bus.fb_sel_out}
          !== {1'b1, 1'b1, AW'(k), bg, 1'b0, ~exp_disp}) begin
        errors++;
        $display("FAIL clear_write[%0d]: got busy=%b we=%b addr=%0d data=%h dstart=%b sel=%b expected busy=1 we=1 addr=%0d data=%h dstart=0 sel=%b",
                 k, busy_out, bus.fb_we_out, bus.fb_addr_out, bus.fb_data_out, bus.draw_start_out,
                 bus.fb_sel_out, k, bg, ~exp_disp);
      end
      if (hold && k == 10) begin
        background_color_in = bg ^ 4'h5;
        num_shapes_in       = n + SW'(2);
      end
      if (k < PW * PH - 1) tick;
    end
    background_color_in = bg;
    num_shapes_in       = n;
  endtask

  // Pulses vsync in WAIT_SWAP and checks the swap cycle.
  task automatic do_swap;
    vsync_in = 1'b1;
    tick;
    vsync_in = 1'b0;
    exp_disp = ~exp_disp;
    checks++;
    if ({frame_done_out, display_buf_out, bus.fb_sel_out, busy_out, bus.fb_we_out}
        !== {1'b1, exp_disp, ~exp_disp, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL swap: got fdone=%b disp=%b sel=%b busy=%b we=%b expected fdone=1 disp=%b sel=%b busy=0 we=0",
               frame_done_out, display_buf_out, bus.fb_sel_out, busy_out, bus.fb_we_out, exp_disp, ~exp_disp);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    rst_in = 1'b1;
    tick;
    tick;
    checks++;
    if ({bus.shape_idx_out, bus.draw_start_out, bus.fb_addr_out, bus.fb_data_out, bus.fb_we_out,
         display_buf_out, bus.fb_sel_out, busy_out, frame_done_out, state_dbg_out}
        !== {SW'(0), 1'b0, AW'(0), 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, S_IDLE}) begin
      errors++;
      $display("FAIL reset_values: got idx=%0d dstart=%b addr=%0d data=%h we=%b disp=%b sel=%b busy=%b fdone=%b st=%0d expected all zero with sel=1",
               bus.shape_idx_out, bus.draw_start_out, bus.fb_addr_out, bus.fb_data_out, bus.fb_we_out,
               display_buf_out, bus.fb_sel_out, busy_out, frame_done_out, state_dbg_out);
    end
    rst_in = 1'b0;
    tick;
    checks++;
    if ({busy_out, bus.fb_we_out, state_dbg_out} !== {1'b0, 1'b0, S_IDLE}) begin
      errors++;
      $display("FAIL reset_release_idle: got busy=%b we=%b st=%0d expected 0 0 0", busy_out, bus.fb_we_out, state_dbg_out);
    end
  endtask

  task automatic test_clear_only;
    run_clear(4'h2, SW'(0), 1'b0);
    tick;
    checks++;
    if ({bus.fb_we_out, busy_out, bus.draw_start_out, state_dbg_out} !== {1'b0, 1'b1, 1'b0, S_SWAP}) begin
      errors++;
      $display("FAIL clear_end: got we=%b busy=%b dstart=%b st=%0d expected 0 1 0 %0d",
               bus.fb_we_out, busy_out, bus.draw_start_out, state_dbg_out, S_SWAP);
    end
    for (int i = 0; i < 3; i++) begin
      tick;
      checks++;
      if ({bus.draw_start_out, frame_done_out, busy_out, display_buf_out} !== {1'b0, 1'b0, 1'b1, exp_disp}) begin
        errors++;
        $display("FAIL clear_wait_swap[%0d]: got dstart=%b fdone=%b busy=%b disp=%b expected 0 0 1 %b",
                 i, bus.draw_start_out, frame_done_out, busy_out, display_buf_out, exp_disp);
      end
    end
    do_swap;
    tick;
    checks++;
    if ({frame_done_out, busy_out, display_buf_out} !== {1'b0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL clear_after_swap: got fdone=%b busy=%b disp=%b expected 0 0 1", frame_done_out, busy_out, display_buf_out);
    end
  endtask

  task automatic test_single_shape;
    run_clear(4'h1, SW'(1), 1'b0);
    tick;
    checks++;
    if ({bus.draw_start_out, bus.shape_idx_out, bus.fb_we_out, state_dbg_out} !== {1'b1, SW'(0), 1'b0, S_DSTRT}) begin
      errors++;
      $display("FAIL single_start: got dstart=%b idx=%0d we=%b st=%0d expected 1 0 0 %0d",
               bus.draw_start_out, bus.shape_idx_out, bus.fb_we_out, state_dbg_out, S_DSTRT);
    end
    set_pixel(0, 0, 4'h5);             // offered in DRAW_START: must be ignored
    tick;
    checks++;
    if ({bus.draw_start_out, bus.fb_we_out, state_dbg_out} !== {1'b0, 1'b0, S_DWAIT}) begin
      errors++;
      $display("FAIL single_pixel_outside_wait: got dstart=%b we=%b st=%0d expected 0 0 %0d",
               bus.draw_start_out, bus.fb_we_out, state_dbg_out, S_DWAIT);
    end
    set_pixel(3, 2, 4'h3);
    tick;
    checks++;
    if ({bus.fb_we_out, bus.fb_addr_out, bus.fb_data_out} !== {1'b1, AW'(19), 4'h3}) begin
      errors++;
      $display("FAIL single_pixel_write: got we=%b addr=%0d data=%h expected we=1 addr=19 data=3",
               bus.fb_we_out, bus.fb_addr_out, bus.fb_data_out);
    end
    set_pixel(8, 1, 4'h3);
    tick;
    checks++;
    if (bus.fb_we_out !== 1'b0) begin
      errors++;
      $display("FAIL single_drop_x_range: got we=%b expected 0", bus.fb_we_out);
    end
    set_pixel(1, 4, 4'h3);
    tick;
    checks++;
    if (bus.fb_we_out !== 1'b0) begin
      errors++;
      $display("FAIL single_drop_y_range: got we=%b expected 0", bus.fb_we_out);
    end
    set_pixel(2, 2, 4'hF);
    tick;
    checks++;
    if (bus.fb_we_out !== 1'b0) begin
      errors++;
      $display("FAIL single_drop_transparent: got we=%b expected 0", bus.fb_we_out);
    end
    bus.draw_valid_in = 1'b0;
    bus.draw_done_in  = 1'b1;
    tick;
    bus.draw_done_in  = 1'b0;
    checks++;
    if ({bus.fb_we_out, bus.draw_start_out, state_dbg_out} !== {1'b0, 1'b0, S_SWAP}) begin
      errors++;
      $display("FAIL single_done: got we=%b dstart=%b st=%0d expected 0 0 %0d",
               bus.fb_we_out, bus.draw_start_out, state_dbg_out, S_SWAP);
    end
    do_swap;
    tick;
  endtask

  task automatic test_three_shapes;
    run_clear(4'h0, SW'(3), 1'b0);
    tick;
    checks++;
    if ({bus.draw_start_out, bus.shape_idx_out} !== {1'b1, SW'(0)}) begin
      errors++;
      $display("FAIL three_start0: got dstart=%b idx=%0d expected 1 0", bus.draw_start_out, bus.shape_idx_out);
    end
    tick;
    set_pixel(1, 0, 4'h7);
    bus.draw_done_in = 1'b1;
    tick;
    bus.draw_valid_in = 1'b0;
    bus.draw_done_in  = 1'b0;
    checks++;
    if ({bus.draw_start_out, bus.shape_idx_out, bus.fb_we_out, bus.fb_addr_out, bus.fb_data_out}
        !== {1'b1, SW'(1), 1'b1, AW'(1), 4'h7}) begin
      errors++;
      $display("FAIL three_start1_with_pixel: got dstart=%b idx=%0d we=%b addr=%0d data=%h expected 1 1 1 1 7",
               bus.draw_start_out, bus.shape_idx_out, bus.fb_we_out, bus.fb_addr_out, bus.fb_data_out);
    end
    tick;
    checks++;
    if ({bus.draw_start_out, state_dbg_out} !== {1'b0, S_DWAIT}) begin
      errors++;
      $display("FAIL three_start_one_cycle: got dstart=%b st=%0d expected 0 %0d", bus.draw_start_out, state_dbg_out, S_DWAIT);
    end
    tick;
    bus.draw_done_in = 1'b1;
    tick;
    bus.draw_done_in = 1'b0;
    checks++;
    if ({bus.draw_start_out, bus.shape_idx_out, bus.fb_we_out} !== {1'b1, SW'(2), 1'b0}) begin
      errors++;
      $display("FAIL three_start2: got dstart=%b idx=%0d we=%b expected 1 2 0", bus.draw_start_out, bus.shape_idx_out, bus.fb_we_out);
    end
    tick;
    vsync_in = 1'b1;                   // vsync in DRAW_WAIT: no swap
    tick;
    vsync_in = 1'b0;
    checks++;
    if ({display_buf_out, frame_done_out, state_dbg_out} !== {exp_disp, 1'b0, S_DWAIT}) begin
      errors++;
      $display("FAIL three_vsync_in_draw: got disp=%b fdone=%b st=%0d expected %b 0 %0d",
               display_buf_out, frame_done_out, state_dbg_out, exp_disp, S_DWAIT);
    end
    set_pixel(7, 3, 4'h9);
    bus.draw_done_in = 1'b1;
    vsync_in         = 1'b1;           // same edge that enters WAIT_SWAP: not seen
    tick;
    bus.draw_valid_in = 1'b0;
    bus.draw_done_in  = 1'b0;
    vsync_in          = 1'b0;
    checks++;
    if ({bus.fb_we_out, bus.fb_addr_out, bus.fb_data_out, bus.draw_start_out, state_dbg_out}
        !== {1'b1, AW'(31), 4'h9, 1'b0, S_SWAP}) begin
      errors++;
      $display("FAIL three_last_pixel: got we=%b addr=%0d data=%h dstart=%b st=%0d expected 1 31 9 0 %0d",
               bus.fb_we_out, bus.fb_addr_out, bus.fb_data_out, bus.draw_start_out, state_dbg_out, S_SWAP);
    end
    tick;
    checks++;
    if ({frame_done_out, display_buf_out, state_dbg_out} !== {1'b0, exp_disp, S_SWAP}) begin
      errors++;
      $display("FAIL three_early_vsync_ignored: got fdone=%b disp=%b st=%0d expected 0 %b %0d",
               frame_done_out, display_buf_out, state_dbg_out, exp_disp, S_SWAP);
    end
    do_swap;
    tick;
  endtask

  task automatic test_clamp_and_ignore;
    run_clear(4'h3, SW'(MS + 3), 1'b1);
    start_in = 1'b0;
    for (int i = 0; i < MS; i++) begin
      tick;
      bus.draw_done_in = 1'b0;
      checks++;
      if ({bus.draw_start_out, bus.shape_idx_out} !== {1'b1, SW'(i)}) begin
        errors++;
        $display("FAIL clamp_start[%0d]: got dstart=%b idx=%0d expected 1 %0d", i, bus.draw_start_out, bus.shape_idx_out, i);
      end
      tick;
      if (i == 5) begin
        vsync_in = 1'b1;
        tick;
        vsync_in = 1'b0;
        checks++;
        if ({display_buf_out, frame_done_out, state_dbg_out} !== {exp_disp, 1'b0, S_DWAIT}) begin
          errors++;
          $display("FAIL clamp_vsync_in_draw: got disp=%b fdone=%b st=%0d expected %b 0 %0d",
                   display_buf_out, frame_done_out, state_dbg_out, exp_disp, S_DWAIT);
        end
      end
      bus.draw_done_in = 1'b1;
    end
    tick;
    bus.draw_done_in = 1'b0;
    checks++;
    if ({bus.draw_start_out, state_dbg_out} !== {1'b0, S_SWAP}) begin
      errors++;
      $display("FAIL clamp_no_extra_start: got dstart=%b st=%0d expected 0 %0d", bus.draw_start_out, state_dbg_out, S_SWAP);
    end
    do_swap;
    tick;
  endtask

  task automatic test_back_to_back;
    logic [2:0] sel_seq;
    sel_seq = 3'b101;
    for (int f = 0; f < 3; f++) begin
      run_clear(4'h6, SW'(0), 1'b1);
      tick;
      checks++;
      if ({state_dbg_out, bus.fb_sel_out} !== {S_SWAP, sel_seq[f]}) begin
        errors++;
        $display("FAIL b2b_sel[%0d]: got st=%0d sel=%b expected %0d %b", f, state_dbg_out, bus.fb_sel_out, S_SWAP, sel_seq[f]);
      end
      do_swap;
      if (f == 2) start_in = 1'b0;
    end
    tick;
    checks++;
    if ({busy_out, state_dbg_out, bus.fb_we_out} !== {1'b0, S_IDLE, 1'b0}) begin
      errors++;
      $display("FAIL b2b_stop: got busy=%b st=%0d we=%b expected 0 0 0", busy_out, state_dbg_out, bus.fb_we_out);
    end
  endtask

  task automatic test_reset_mid_draw;
    run_clear(4'h4, SW'(1), 1'b0);
    tick;
    tick;
    set_pixel(0, 1, 4'h2);
    tick;
    bus.draw_valid_in = 1'b0;
    checks++;
    if ({bus.fb_we_out, bus.fb_addr_out, bus.fb_data_out, display_buf_out} !== {1'b1, AW'(8), 4'h2, 1'b1}) begin
      errors++;
      $display("FAIL rst_pre_write: got we=%b addr=%0d data=%h disp=%b expected 1 8 2 1",
               bus.fb_we_out, bus.fb_addr_out, bus.fb_data_out, display_buf_out);
    end
    #2;
    rst_in = 1'b1;
    #1;
    exp_disp = 1'b0;
    checks++;
    if ({bus.fb_we_out, busy_out, display_buf_out, bus.fb_sel_out, bus.draw_start_out, state_dbg_out}
        !== {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, S_IDLE}) begin
      errors++;
      $display("FAIL rst_async: got we=%b busy=%b disp=%b sel=%b dstart=%b st=%0d expected 0 0 0 1 0 0",
               bus.fb_we_out, busy_out, display_buf_out, bus.fb_sel_out, bus.draw_start_out, state_dbg_out);
    end
    tick;
    tick;
    rst_in = 1'b0;
    tick;
    checks++;
    if ({busy_out, bus.fb_we_out} !== {1'b0, 1'b0}) begin
      errors++;
      $display("FAIL rst_after_release: got busy=%b we=%b expected 0 0", busy_out, bus.fb_we_out);
    end
    run_clear(4'hA, SW'(0), 1'b0);
    tick;
    checks++;
    if (state_dbg_out !== S_SWAP) begin
      errors++;
      $display("FAIL rst_reclear_end: got st=%0d expected %0d", state_dbg_out, S_SWAP);
    end
    do_swap;
    tick;
  endtask

  // ---------------- main sequence + report ----------------
  initial begin
    rst_in              = 1'b1;
    start_in            = 1'b0;
    vsync_in            = 1'b0;
    background_color_in = '0;
    num_shapes_in       = '0;
    bus.draw_hcount_in  = '0;
    bus.draw_vcount_in  = '0;
    bus.draw_color_in   = '0;
    bus.draw_valid_in   = 1'b0;
    bus.draw_done_in    = 1'b0;

    test_reset;
    test_clear_only;
    test_single_shape;
    test_three_shapes;
    test_clamp_and_ignore;
    test_back_to_back;
    test_reset_mid_draw;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/render_sequencer.md
# render_sequencer

Frame-level render controller that produces one complete frame in a double-buffered framebuffer. On request it clears the back buffer to a background colour and then runs a list of up to MAX_SHAPES shapes through an external shape drawer, one after another. It forwards each drawn pixel to the framebuffer write port after bounds and transparency checks. Buffers swap on the next vsync. It sits between the game/physics logic (start, shape count) and the dual-port pixel RAM and palette read path.

## Interface
- PIXEL_WIDTH, 1280: image width in pixels.
- PIXEL_HEIGHT, 720: image height in pixels.
- COLOR_BITS, 4: palette index width.
- MAX_SHAPES, 16: maximum shapes per frame.
- TRANSPARENT, 4'hF: palette index the sequencer never writes during draw.
- Derived values:
  - AW = $clog2(PIXEL_WIDTH*PIXEL_HEIGHT).
  - HW = $clog2(PIXEL_WIDTH).
  - VW = $clog2(PIXEL_HEIGHT).
  - SW = $clog2(MAX_SHAPES+1).

Ports:
- clk_in  in  1  system clock. One clock domain; everything is synchronous to it.
- rst_in  in  1  reset, asynchronous, active-high.
- start_in  in  1  frame request. Sampled only in IDLE.
- vsync_in  in  1  single-cycle frame-boundary pulse.
- background_color_in  in  COLOR_BITS  clear colour. Latched on start.
- num_shapes_in  in  SW  shape count. Latched on start. Values above MAX_SHAPES are clamped to MAX_SHAPES.
- shape_idx_out  out  SW  index of the shape currently being drawn.
- draw_start_out  out  1  one-cycle start pulse to the drawer.
- draw_hcount_in  in  HW+1  drawer pixel x. Unsigned; may be out of range.
- draw_vcount_in  in  VW+1  drawer pixel y. Unsigned; may be out of range.
- draw_color_in  in  COLOR_BITS  drawer pixel colour.
- draw_valid_in  in  1  drawer pixel is valid this cycle.
- draw_done_in  in  1  drawer finished the current shape.
- fb_addr_out  out  AW  write address, x + PIXEL_WIDTH*y.
- fb_data_out  out  COLOR_BITS  write data.
- fb_we_out  out  1  write enable.
- fb_sel_out  out  1  buffer being written. Always the inverse of display_buf_out.
- display_buf_out  out  1  buffer selected for scan-out.
- busy_out  out  1  high in every state except IDLE.
- frame_done_out  out  1  one-cycle pulse on buffer swap.

## Operation
- States: IDLE, CLEAR, DRAW_START, DRAW_WAIT, WAIT_SWAP.
- IDLE:
  - start_in=1 latches background colour and the clamped shape count, zeroes the clear counter, and goes to CLEAR.
- CLEAR:
  - Writes background_color to addresses 0 .. PIXEL_WIDTH*PIXEL_HEIGHT-1, one per cycle, ascending.
  - After the last address: go to DRAW_START if count > 0, otherwise to WAIT_SWAP.
- DRAW_START:
  - Asserts draw_start_out for exactly one cycle with shape_idx_out = current index, then goes to DRAW_WAIT.
- DRAW_WAIT: a drawer pixel is forwarded only if all of the following hold:
  - draw_valid_in = 1;
  - draw_hcount_in < PIXEL_WIDTH;
  - draw_vcount_in < PIXEL_HEIGHT;
  - draw_color_in != TRANSPARENT.
- Pixels that fail these checks are dropped silently.
- draw_done_in behaviour:
  - If the index is at the last shape (count-1), go to WAIT_SWAP.
  - Otherwise increment the index and return to DRAW_START.
  - A valid pixel in the same cycle as draw_done_in is still forwarded.
- WAIT_SWAP:
  - vsync_in=1 toggles display_buf_out, pulses frame_done_out, and returns to IDLE.
- Ignored inputs:
  - start_in in any state other than IDLE.
  - vsync_in outside WAIT_SWAP.
  - draw_valid_in and draw_done_in outside DRAW_WAIT.
- Address arithmetic is y*PIXEL_WIDTH + x, computed at AW bits after the range check, so it never wraps.
- Reset in any state:
  - State returns to IDLE immediately.
  - The partial frame is abandoned.
  - display_buf_out is forced to 0.
  - No further write occurs.

## Timing
- Reset values:
  - State IDLE.
  - shape_idx_out 0, draw_start_out 0, fb_addr_out 0, fb_data_out 0, fb_we_out 0.
  - display_buf_out 0, so fb_sel_out 1.
  - busy_out 0, frame_done_out 0.
- All outputs are registered.
- Clear phase:
  - start_in sampled at edge T.
  - busy_out and fb_we_out rise at T+1 with fb_addr_out 0.
  - The last clear write, address N-1 where N = PIXEL_WIDTH*PIXEL_HEIGHT, is at T+N.
- First draw:
  - draw_start_out is high in cycle T+N+1.
- Pixel forwarding:
  - Latency is exactly 1 cycle. A valid pixel sampled at edge E appears on the fb_* outputs in cycle E+1.
  - fb_we_out is high for one cycle per forwarded pixel.
- Next shape:
  - draw_done_in sampled at edge D gives draw_start_out for the next shape in cycle D+1.
- Swap:
  - vsync_in sampled at edge S: display_buf_out toggles, frame_done_out is high, and busy_out falls, all in cycle S+1.
  - A vsync arriving in the cycle the state enters WAIT_SWAP is not seen; the sequencer waits for the next one.
- Zero shapes:
  - draw_start_out is never asserted.
  - WAIT_SWAP is entered in cycle T+N+1.

## Test plan
- Clear only: PIXEL_WIDTH=8, PIXEL_HEIGHT=4, num_shapes 0, background 4'h2.
  - 32 consecutive writes, addresses 0..31, data 2.
  - No draw_start_out.
  - vsync gives frame_done_out and display_buf_out 0 -> 1.
- Single shape, 8x4: drawer emits (3,2,color 3) then (8,1,3), (1,4,3), (2,2,4'hF), then done.
  - Exactly one drawer write: addr 19, data 3.
  - One-cycle latency.
- Three shapes:
  - draw_start_out pulses with shape_idx_out 0, 1, 2, each one cycle after the previous draw_done_in.
  - Pixel and done in the same cycle: the pixel is still written.
- Clamp and ignore:
  - num_shapes_in = MAX_SHAPES+3 gives exactly MAX_SHAPES starts.
  - start_in during CLEAR has no effect.
  - vsync during DRAW_WAIT does not swap.
- Reset mid-draw:
  - rst_in asserted between clock edges during DRAW_WAIT after one swap.
  - fb_we_out and busy_out go low and display_buf_out goes to 0 immediately, before any clock edge.
  - A new start after release performs the full 32-write clear.
- Back-to-back frames:
  - start_in held high continuously.
  - A new frame begins one cycle after frame_done_out.
  - fb_sel_out alternates 1, 0, 1 across frames.
